// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential nibble multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB = 4;

  // Left shift that places the partial product of nibble pair (i, j).
  function automatic int unsigned shift_amt(input int unsigned i, input int unsigned j);
    return NIB * (i + j);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle for mult_seq_ctrl.
// Optional signed_mode signal exists only when MULT_SEQ_SIGNED_EN is defined.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; a source holds its payload stable while valid is high and ready low.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 16
) ();
  import mult_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;
  state_t             dbg_state;
`ifdef MULT_SEQ_SIGNED_EN
  logic               signed_mode;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p, busy, dbg_state
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p, busy, dbg_state
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy, dbg_state
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy, dbg_state
  );
`endif

endinterface

// File: rtl/mult_seq_ctrl_wallace4.sv
// Purely combinational 4x4 unsigned Wallace-tree multiplier:
// two carry-save rows reduce four partial products, one final adder resolves.
module mult_seq_ctrl_wallace4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] prod
);

  logic [7:0] r0, r1, r2, r3;
  logic [7:0] s1, c1, s2, c2;

  assign r0 = {4'b0000, x & {4{y[0]}}};
  assign r1 = {3'b000,  x & {4{y[1]}}, 1'b0};
  assign r2 = {2'b00,   x & {4{y[2]}}, 2'b00};
  assign r3 = {1'b0,    x & {4{y[3]}}, 3'b000};

  assign s1 = r0 ^ r1 ^ r2;
  assign c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;

  assign s2 = s1 ^ c1 ^ r3;
  assign c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;

  // Product never exceeds 8 bits, so modulo-256 carry-save arithmetic is exact.
  assign prod = s2 + c2;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier: one 4x4 Wallace core swept over all nibble pairs.
// Define MULT_SEQ_SIGNED_EN to add two's-complement operation via bus.signed_mode.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_seq_ctrl_if.slave bus
);

  localparam int N  = WIDTH / NIB;
  localparam int IW = $clog2(N * N);
  localparam int HW = IW / 2;
  localparam logic [IW-1:0] LAST = IW'(N * N - 1);

  state_t             state;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [IW-1:0]      idx;

  logic [HW-1:0]      ni;
  logic [HW-1:0]      nj;
  logic [7:0]         pp;
  logic [2*WIDTH-1:0] term;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a_lat;
  logic [WIDTH-1:0]   b_lat;

  // N is a power of two, so idx splits cleanly into i (high half) and j (low half).
  assign ni = idx[IW-1:HW];
  assign nj = idx[HW-1:0];

  mult_seq_ctrl_wallace4 u_core (
    .x    (a_reg[NIB*ni +: NIB]),
    .y    (b_reg[NIB*nj +: NIB]),
    .prod (pp)
  );

  assign term     = {{(2*WIDTH-8){1'b0}}, pp} << shift_amt(32'(ni), 32'(nj));
  assign acc_next = acc + term;

`ifdef MULT_SEQ_SIGNED_EN
  logic sign_reg;

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
  assign a_lat  = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_lat  = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign result = sign_reg ? -acc_next : acc_next;
`else
  assign a_lat  = bus.a;
  assign b_lat  = bus.b;
  assign result = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      p_q         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      idx         <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      sign_reg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= a_lat;
            b_reg      <= b_lat;
            acc        <= '0;
            idx        <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            sign_reg   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`endif
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= MUL;
          end
        end
        MUL: begin
          acc <= acc_next;
          if (idx == LAST) begin
            p_q         <= result;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // No accept on the handoff edge; IDLE reopens in_ready next cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.p         = p_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl (WIDTH=16); signed vectors run when MULT_SEQ_SIGNED_EN is defined.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  localparam int WIDTH = 16;
  localparam int NN    = (WIDTH / 4) * (WIDTH / 4);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic sm);
`ifdef MULT_SEQ_SIGNED_EN
    bus.signed_mode = sm;
`else
    if (sm) $display("note: signed_mode ignored in unsigned build");
`endif
  endtask

  // Driver: offer one operand pair, wait for the product, optionally stall the
  // consumer for `hold` cycles, then retire it.
  task automatic do_mult(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sm, input logic [31:0] exp, input int hold,
                         input bit scramble);
    int  lat;
    bit  seen;
    logic [31:0] exp_q[$];
    exp_q.push_back(exp);
    @(negedge clk);
    bus.a        = av;
    bus.b        = bv;
    set_mode(sm);
    bus.in_valid = 1'b1;
    check({tag, ".in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 4 * NN; n++) begin
      if (scramble) begin
        bus.a         = 16'($urandom);
        bus.b         = 16'($urandom);
        bus.out_ready = 1'($urandom_range(0, 1));
        set_mode(1'($urandom_range(0, 1)));
      end
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
    end
    bus.out_ready = 1'b0;
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(NN));
    check({tag, ".p"}, bus.p, exp_q[0]);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".hold_p"}, bus.p, exp_q[0]);
      check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".retired_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".retired_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, ".retired_state"}, 32'(bus.dbg_state), 32'(IDLE));
    void'(exp_q.pop_front());
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    set_mode(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.p", bus.p, 32'd0);
    check("rst.state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    do_mult("basic",   16'h04D2, 16'h162E, 1'b0, 32'h006AE9BC, 0, 1'b0);
    do_mult("max",     16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, 1'b0);
    do_mult("zero",    16'h0000, 16'hBEEF, 1'b0, 32'h00000000, 0, 1'b0);
    do_mult("byte",    16'h00FF, 16'h0100, 1'b0, 32'h0000FF00, 0, 1'b0);
    do_mult("shift4",  16'h1234, 16'h0010, 1'b0, 32'h00012340, 0, 1'b0);
    do_mult("one",     16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, 0, 1'b0);
    do_mult("bkpr",    16'h0003, 16'h0007, 1'b0, 32'h00000015, 5, 1'b0);

    // In IDLE with in_valid low nothing starts.
    @(posedge clk);
    #1;
    check("idle_stays.busy", 32'(bus.busy), 32'd0);

    // Abort in the middle of MUL.
    @(negedge clk);
    bus.a        = 16'hABCD;
    bus.b        = 16'h1234;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midrst.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.p", bus.p, 32'd0);
    check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    do_mult("after_rst", 16'h0064, 16'h00C8, 1'b0, 32'h00004E20, 0, 1'b0);

    // Operands and out_ready wiggle throughout MUL and must not matter.
    do_mult("scramble",  16'h0003, 16'h0007, 1'b0, 32'h00000015, 0, 1'b1);

`ifdef MULT_SEQ_SIGNED_EN
    do_mult("s.neg3x5",   16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 0, 1'b0);
    do_mult("s.min_sq",   16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, 1'b0);
    do_mult("s.m1xm1",    16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 0, 1'b0);
    do_mult("s.max_min",  16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 0, 1'b0);
    do_mult("u.neg3x5",   16'hFFFD, 16'h0005, 1'b0, 32'h0004FFF1, 0, 1'b0);
    do_mult("u.min_sq",   16'h8000, 16'h8000, 1'b0, 32'h40000000, 0, 1'b0);
    do_mult("u.max_min",  16'h7FFF, 16'h8000, 1'b0, 32'h3FFF8000, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
